ifu_line_fill: RTL
==================

IFU_LINE_FILL -- requirements
Module: ifu_line_fill

Interface
REQ-001 Parameter: BEATS, 4, 32-bit memory response beats per 128-bit line.
REQ-002 Parameter: WORD_W, 32, width of one memory response beat.
REQ-003 Clock  in  1  clock; all state updates on posedge Clock.
REQ-004 Rst  in  1  reset, synchronous, active-high.
REQ-005 MissValid  in  1  cache reports a miss for MissPc.
REQ-006 MissPc  in  32  pc that missed.
REQ-007 MissReady  out  1  unit can accept a miss.
REQ-008 MemReqValid  out  1  line read request to memory.
REQ-009 MemReqAddr  out  32  line-aligned request address.
REQ-010 MemReqReady  in  1  memory accepts the request.
REQ-011 MemRspValid  in  1  response beat valid; no backpressure.
REQ-012 MemRspData  in  32  response beat data, word 0 first.
REQ-013 FlushIn  in  1  pc redirect; abandon the current fill.
REQ-014 LineOut  out  128  assembled line to the instruction cache.
REQ-015 LineValidOut  out  1  one-cycle pulse; LineOut and LineAddrOut valid.
REQ-016 LineAddrOut  out  32  line-aligned address of LineOut.

Function
REQ-017 FSM states SHALL be IDLE, REQ, RESP, DONE.
REQ-018 IDLE: MissReady=1; MissValid=1 and FlushIn=0 SHALL capture {MissPc[31:4],4'h0} into the address register and go to REQ.
REQ-019 REQ: MemReqValid=1, MemReqAddr=the captured address; MemReqValid=1 and MemReqReady=1 SHALL go to RESP with beat counter=0.
REQ-020 MemReqValid and MemReqAddr SHALL stay stable in REQ until the handshake completes.
REQ-021 RESP: each MemRspValid SHALL write MemRspData to LineOut[32k+31:32k], k=beat counter, and increment the 2-bit counter.
REQ-022 A beat with counter=BEATS-1 SHALL go to DONE, or to IDLE if the drop flag is set or FlushIn=1 in that cycle.
REQ-023 DONE: LineValidOut=1 for exactly one cycle, LineAddrOut=the captured address; next state IDLE.
REQ-024 Latency: miss accepted at cycle t -> MemReqValid=1 at t+1; last beat at cycle u -> LineValidOut=1 at u+1, MissReady=1 at u+2.
REQ-025 FlushIn in IDLE SHALL be ignored, and a simultaneous MissValid SHALL NOT be accepted.
REQ-026 FlushIn in REQ before the handshake SHALL go to IDLE with no memory request issued; FlushIn coincident with MemReqReady SHALL take RESP with the drop flag set.
REQ-027 FlushIn in RESP SHALL set the drop flag; the remaining beats SHALL be consumed and discarded, with no LineValidOut and no further MemReqValid.
REQ-028 FlushIn in DONE SHALL NOT suppress the pulse, since the line is already complete.
REQ-029 MemRspValid in IDLE, REQ or DONE SHALL be ignored and SHALL NOT alter LineOut.
REQ-030 LineOut and LineAddrOut SHALL hold their values between fills.
REQ-031 The beat counter SHALL wrap 3->0; the drop flag SHALL clear on entry to IDLE.

Reset
REQ-032 Rst SHALL force state=IDLE, beat counter=0, drop flag=0.
REQ-033 Rst SHALL force LineOut=0, LineAddrOut=0, LineValidOut=0, MemReqValid=0, MemReqAddr=0.
REQ-034 Rst SHALL force MissReady=1 in the first cycle after reset.
REQ-035 Rst mid-fill SHALL abandon the fill with no pulse; beats arriving after reset SHALL be ignored (IDLE).

Structure
REQ-036 Package ifu_pkg SHALL hold LINE_W=128, OFFSET_WIDTH=4, the fill-state enum t_fill_state and the line type t_line.
REQ-037 No sub-module; single module with FSM, counter and line register.

Verification
REQ-038 Basic fill: MissPc=0x0000_1234, MemReqReady=1, beats 0x11,0x22,0x33,0x44 back-to-back -> MemReqAddr=0x0000_1230; LineOut=0x00000044_00000033_00000022_00000011, one-cycle LineValidOut.
REQ-039 Request stall: MemReqReady=0 for 5 cycles -> MemReqValid and MemReqAddr stay stable; the fill then completes normally.
REQ-040 Flush in REQ: FlushIn at cycle 2 of REQ -> IDLE, no handshake, no LineValidOut.
REQ-041 Flush mid-response: FlushIn after beat 1 -> beats 2 and 3 consumed, no LineValidOut, MissReady=1 the cycle after beat 3.
REQ-042 Gapped beats: 3 idle cycles between beats, stray MemRspValid in IDLE -> correct line assembled; LineOut unchanged in IDLE.
REQ-043 Reset after beat 2 -> all outputs 0, IDLE; the next miss fills correctly.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch line fill unit.
// Holds the line geometry, the fill FSM state encoding and the line type.
// A helper aligns a fetch pc down to its line base address.
package ifu_pkg;

    localparam int LINE_W       = 128;
    localparam int OFFSET_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } t_fill_state;

    typedef logic [LINE_W-1:0] t_line;

    // Clear the byte-offset bits so the address names the first byte of the line.
    function automatic logic [31:0] line_align(input logic [31:0] pc);
        logic [31:0] offset_mask;
        offset_mask = 32'((1 << OFFSET_WIDTH) - 1);
        return pc & ~offset_mask;
    endfunction

endpackage

// File: rtl/ifu_line_fill.sv
// Purpose: on an I-cache miss, issue one line read to memory, assemble BEATS
//          response beats into a 128-bit line and hand it to the cache.
// Latency: miss accepted at t -> request at t+1; last beat at u -> LineValidOut at u+1,
//          MissReady at u+2. Backpressure: request waits on MemReqReady; responses
//          cannot be stalled, and MissReady is low for the whole fill.
// Ports:   Clock/Rst (sync, active-high); MissValid/MissPc/MissReady from the cache;
//          MemReq*/MemRsp* to memory; FlushIn redirect; LineOut/LineValidOut/LineAddrOut.
module ifu_line_fill
    import ifu_pkg::*;
#(
    parameter int BEATS  = 4,
    parameter int WORD_W = 32
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              MissValid,
    input  logic [31:0]       MissPc,
    output logic              MissReady,
    output logic              MemReqValid,
    output logic [31:0]       MemReqAddr,
    input  logic              MemReqReady,
    input  logic              MemRspValid,
    input  logic [WORD_W-1:0] MemRspData,
    input  logic              FlushIn,
    output t_line             LineOut,
    output logic              LineValidOut,
    output logic [31:0]       LineAddrOut
);

    localparam int CNT_W = $clog2(BEATS);

    t_fill_state      state_q;
    t_fill_state      state_d;
    logic [31:0]      addr_q;
    logic [31:0]      line_addr_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic             drop_q;
    t_line            line_q;
    logic             last_beat;
    logic             keep_beat;

    assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
    // A beat is kept only for a fill that has not been redirected, including
    // a redirect arriving in the same cycle as the beat.
    assign keep_beat = !drop_q && !FlushIn;

    // State register plus the datapath registers that follow it.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            line_addr_q <= '0;
            beat_cnt_q  <= '0;
            drop_q      <= 1'b0;
            line_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (MissValid && !FlushIn) begin
                        addr_q <= line_align(MissPc);
                    end
                end
                REQ: begin
                    if (MemReqReady) begin
                        beat_cnt_q <= '0;
                        // Request already accepted: memory will still send the
                        // beats, so a coincident redirect has to drain them.
                        drop_q     <= FlushIn;
                    end
                end
                RESP: begin
                    if (FlushIn) begin
                        drop_q <= 1'b1;
                    end
                    if (MemRspValid) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (keep_beat) begin
                            line_q[int'(beat_cnt_q)*WORD_W +: WORD_W] <= MemRspData;
                            if (last_beat) begin
                                line_addr_q <= addr_q;
                            end
                        end
                    end
                end
                default: ;
            endcase
            if (state_d == IDLE) begin
                drop_q <= 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (MissValid && !FlushIn) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (MemReqReady) begin
                    state_d = RESP;
                end else if (FlushIn) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (MemRspValid && last_beat) begin
                    state_d = keep_beat ? DONE : IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; the pulse in DONE is unconditional because the line is complete.
    always_comb begin
        MissReady    = 1'b0;
        MemReqValid  = 1'b0;
        LineValidOut = 1'b0;
        case (state_q)
            IDLE:    MissReady    = 1'b1;
            REQ:     MemReqValid  = 1'b1;
            DONE:    LineValidOut = 1'b1;
            default: ;
        endcase
    end

    assign MemReqAddr  = addr_q;
    assign LineOut     = line_q;
    assign LineAddrOut = line_addr_q;

endmodule
